// File: rtl/fifo_umbrales_if.sv
// Handshake and status bundle between fifo_umbrales and its producer/consumer.
// The master side drives push/pop/data and thresholds; the slave is the FIFO.
interface fifo_umbrales_if #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int PTR_SIZE       = 3
);
  logic                      push;
  logic                      pop;
  logic [FIFO_WORD_SIZE-1:0] data_in;
  logic [PTR_SIZE:0]         umbral_af;
  logic [PTR_SIZE:0]         umbral_ae;
  logic [FIFO_WORD_SIZE-1:0] data_out;
  logic [PTR_SIZE:0]         count;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output push, pop, data_in,
    output umbral_af, umbral_ae,
    input  data_out, count,
    input  full, empty,
    input  almost_full, almost_empty,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    input  umbral_af, umbral_ae,
    output data_out, count,
    output full, empty,
    output almost_full, almost_empty,
    output overflow, underflow
  );
endinterface

// File: rtl/fifo_umbrales.sv
// First-word-fall-through FIFO with programmable almost-full/empty
// thresholds and sticky overflow/underflow error flags.
module fifo_umbrales #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int PTR_SIZE       = 3
) (
  input logic          clk,
  input logic          reset_L,
  fifo_umbrales_if.slave bus
);

  localparam logic [PTR_SIZE:0] DEPTH_C = (PTR_SIZE+1)'(FIFO_DEPTH);

  logic [FIFO_WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_SIZE-1:0]       wr_ptr;
  logic [PTR_SIZE-1:0]       rd_ptr;
  logic [PTR_SIZE:0]         count;
  logic                      overflow;
  logic                      underflow;

  logic full_w;
  logic empty_w;
  logic push_ok;
  logic pop_ok;

  assign full_w  = (count == DEPTH_C);
  assign empty_w = (count == '0);

  // A pop while full frees the slot the push needs.
  assign push_ok = bus.push && (!full_w || bus.pop);
  assign pop_ok  = bus.pop && !empty_w;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mem       <= '{default: '0};
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.push && full_w && !bus.pop)
        overflow <= 1'b1;
      if (bus.pop && empty_w)
        underflow <= 1'b1;
    end
  end

  assign bus.data_out     = empty_w ? '0 : mem[rd_ptr];
  assign bus.count        = count;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count >= bus.umbral_af);
  assign bus.almost_empty = (count <= bus.umbral_ae);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed testbench for fifo_umbrales: reset, fill, overflow, drain,
// underflow, wrap-around pass-through, thresholds and mid-burst reset.
module tb_fifo_umbrales;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  fifo_umbrales_if #(.FIFO_WORD_SIZE(10), .PTR_SIZE(3)) bus ();

  fifo_umbrales #(
    .FIFO_WORD_SIZE(10),
    .FIFO_DEPTH(8),
    .PTR_SIZE(3)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_L = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.umbral_af = 4'd0;
    bus.umbral_ae = 4'd1;
    idle();
    reset_L = 1'b0;
    #3;
    checks++;
    if (bus.almost_full !== 1'b1) begin
      errors++;
      $display("FAIL reset_af0 got %b exp 1", bus.almost_full);
    end
    bus.umbral_af = 4'd6;
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0
        || bus.data_out !== 10'h000) begin
      errors++;
      $display("FAIL reset_state cnt %0d empty %b full %b dout %h exp 0 1 0 000",
               bus.count, bus.empty, bus.full, bus.data_out);
    end
    checks++;
    if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0
        || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ae %b af %b ov %b un %b exp 1 0 0 0",
               bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow);
    end
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      bus.push    = 1'b1;
      bus.data_in = 10'(i);
      tick();
      checks++;
      if (bus.count !== 4'(i) || bus.data_out !== 10'h001
          || bus.almost_full !== (i >= 6)) begin
        errors++;
        $display("FAIL fill_%0d cnt %0d dout %h af %b exp %0d 001 %b",
                 i, bus.count, bus.data_out, bus.almost_full, i, (i >= 6));
      end
    end
    idle();
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL fill_full full %b cnt %0d exp 1 8", bus.full, bus.count);
    end
  endtask

  task automatic test_overflow();
    bus.push    = 1'b1;
    bus.data_in = 10'h3FF;
    tick();
    idle();
    checks++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b1
        || bus.data_out !== 10'h001) begin
      errors++;
      $display("FAIL overflow cnt %0d ov %b dout %h exp 8 1 001",
               bus.count, bus.overflow, bus.data_out);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.data_out !== 10'(i + 1)) begin
        errors++;
        $display("FAIL drain_data_%0d got %h exp %h", i, bus.data_out, 10'(i + 1));
      end
      bus.pop = 1'b1;
      tick();
      checks++;
      if (bus.count !== 4'(7 - i) || bus.almost_empty !== ((7 - i) <= 1)) begin
        errors++;
        $display("FAIL drain_cnt_%0d cnt %0d ae %b exp %0d %b",
                 i, bus.count, bus.almost_empty, 7 - i, ((7 - i) <= 1));
      end
    end
    idle();
    checks++;
    if (bus.empty !== 1'b1 || bus.data_out !== 10'h000 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_end empty %b dout %h un %b exp 1 000 0",
               bus.empty, bus.data_out, bus.underflow);
    end
  endtask

  task automatic test_underflow();
    bus.push    = 1'b1;
    bus.pop     = 1'b1;
    bus.data_in = 10'h2A5;
    tick();
    idle();
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 4'd1 || bus.data_out !== 10'h2A5) begin
      errors++;
      $display("FAIL underflow un %b cnt %0d dout %h exp 1 1 2a5",
               bus.underflow, bus.count, bus.data_out);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b exp 1", bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] q[$];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.push    = 1'b1;
      bus.data_in = 10'h020 + 10'(i);
      q.push_back(10'h020 + 10'(i));
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus.data_out !== q[0] || bus.count !== 4'd8) begin
        errors++;
        $display("FAIL wrap_%0d dout %h cnt %0d exp %h 8",
                 i, bus.data_out, bus.count, q[0]);
      end
      bus.push    = 1'b1;
      bus.pop     = 1'b1;
      bus.data_in = 10'h100 + 10'(i);
      void'(q.pop_front());
      q.push_back(10'h100 + 10'(i));
      tick();
    end
    idle();
    checks++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0
        || bus.data_out !== 10'h104) begin
      errors++;
      $display("FAIL wrap_end cnt %0d ov %b un %b dout %h exp 8 0 0 104",
               bus.count, bus.overflow, bus.underflow, bus.data_out);
    end
  endtask

  task automatic test_thresholds();
    bus.umbral_af = 4'd9;
    bus.umbral_ae = 4'd8;
    #1;
    checks++;
    if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL thr_a af %b ae %b exp 0 1", bus.almost_full, bus.almost_empty);
    end
    bus.umbral_af = 4'd8;
    bus.umbral_ae = 4'd7;
    #1;
    checks++;
    if (bus.almost_full !== 1'b1 || bus.almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL thr_b af %b ae %b exp 1 0", bus.almost_full, bus.almost_empty);
    end
    bus.umbral_af = 4'd6;
    bus.umbral_ae = 4'd1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.push    = 1'b1;
      bus.data_in = 10'h050 + 10'(i);
      tick();
    end
    idle();
    checks++;
    if (bus.count !== 4'd5 || bus.data_out !== 10'h050) begin
      errors++;
      $display("FAIL mid_pre cnt %0d dout %h exp 5 050", bus.count, bus.data_out);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0
        || bus.data_out !== 10'h000 || bus.almost_empty !== 1'b1
        || bus.almost_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_async cnt %0d empty %b full %b dout %h ae %b af %b exp 0 1 0 000 1 0",
               bus.count, bus.empty, bus.full, bus.data_out,
               bus.almost_empty, bus.almost_full);
    end
    #1;
    reset_L = 1'b1;
    bus.push    = 1'b1;
    bus.data_in = 10'h0C3;
    tick();
    idle();
    checks++;
    if (bus.data_out !== 10'h0C3 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL mid_after dout %h cnt %0d exp 0c3 1", bus.data_out, bus.count);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_L = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_thresholds();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Synchronous first-word-fall-through FIFO with programmable almost-full and almost-empty thresholds. It is the storage stage that the transaction-layer arbiter pops from on its input side and pushes into on its output side. The head word is always presented combinationally, so the arbiter's same-cycle pop/data handshake works without extra latency. Count, threshold flags and sticky overflow/underflow errors are exported for the arbiter and for bench checking.

## Interface
- FIFO_WORD_SIZE, 10, data word width in bits; the top 2 bits are the destination field used downstream.
- FIFO_DEPTH, 8, number of entries; must be a power of two.
- PTR_SIZE, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  1  write enable; captures data_in at the rising edge.
- pop  input  1  read enable; retires the head word at the rising edge.
- data_in  input  FIFO_WORD_SIZE  word to store.
- umbral_af  input  PTR_SIZE+1  almost-full threshold.
- umbral_ae  input  PTR_SIZE+1  almost-empty threshold.
- data_out  output  FIFO_WORD_SIZE  current head word; 0 when empty.
- count  output  PTR_SIZE+1  occupancy, 0..FIFO_DEPTH.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= umbral_af.
- almost_empty  output  1  count <= umbral_ae.
- overflow  output  1  sticky; set by a rejected push.
- underflow  output  1  sticky; set by a pop while empty.

## Operation
- **Storage:** FIFO_DEPTH x FIFO_WORD_SIZE register array, plus wr_ptr, rd_ptr (PTR_SIZE bits) and count (PTR_SIZE+1 bits).
- **Pointers:** increment modulo FIFO_DEPTH; wrap from FIFO_DEPTH-1 to 0 is natural truncation.
- **Accepted push:** push=1 and (not full, or pop=1 while full). The word is written at wr_ptr and wr_ptr increments.
- **Rejected push:** push=1, full=1, pop=0. The word is discarded, no state changes, overflow is set.
- **Accepted pop:** pop=1 and not empty. rd_ptr increments.
- **Pop while empty:** pointers unchanged, underflow is set. A simultaneous push is still accepted.
- **Count update:**
  - +1 on accepted push only.
  - -1 on accepted pop only.
  - Unchanged when both are accepted or neither is.
- **Simultaneous push+pop:**
  - When full: both accepted, count stays FIFO_DEPTH.
  - When empty: push accepted, pop is an underflow, count becomes 1.
- **data_out:** combinational mem[rd_ptr] when count != 0, else 0. There is no read latency; the consumer samples it in the same cycle it asserts pop.
- **Flags:** full, empty, almost_full and almost_empty are combinational from the count register and the threshold inputs.
  - umbral_af=0 forces almost_full=1.
  - umbral_ae >= FIFO_DEPTH forces almost_empty=1.
  - Thresholds may change at any time; flags follow in the same cycle.
- **Error flags:** overflow and underflow clear only on reset.
- **Reset (asynchronous, reset_L=0):**
  - Pointers, count, every memory word and both error flags go to 0 immediately, independent of clk.
  - Outputs during and after reset: data_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(umbral_af==0), overflow=0, underflow=0.
  - A reset asserted mid-burst discards all contents. push/pop are ignored while reset_L=0.
  - Deassertion takes effect at the first rising edge after reset_L=1.

## Timing
- Write-to-read latency: a word pushed at edge N appears on data_out after edge N, when the FIFO was empty.
- Pop at edge N: data_out shows the next word after edge N.
- Flags and count change only after a clock edge or on reset. Threshold changes are the only exception: they affect the flags combinationally.
- There is no combinational path from push/pop to any output.
- The consumer must gate pop on !empty. The producer must gate push on !full, or on !almost_full when it needs margin.

## Test plan
- **Reset and fill:** hold reset_L=0, then release. Push 0x001..0x008 on consecutive edges with umbral_af=6 and umbral_ae=1.
  - almost_full rises after the 6th push.
  - full=1 and count=8 after the 8th push.
  - data_out=0x001 throughout.
- **Drain:** from full, pop 8 times.
  - data_out sequence is 0x001..0x008.
  - almost_empty rises when count=1.
  - empty=1, data_out=0 after the 8th pop.
  - underflow stays 0.
- **Overflow:** from full, push 0x3FF with pop=0.
  - count stays 8, overflow=1.
  - Draining returns the original 8 words; 0x3FF never appears.
- **Underflow and simultaneous ops on empty:** when empty, pop=1 with push=1 and data_in=0x2A5.
  - underflow=1, count=1, data_out=0x2A5.
- **Full pass-through and wrap-around:** from full, push+pop for 12 cycles with data 0x100+i.
  - count stays 8, no error flags.
  - Output order is exactly FIFO order across pointer wrap.
- **Mid-operation reset:** with count=5, pulse reset_L low between clock edges.
  - All outputs take their reset values immediately, without waiting for an edge.
  - After release, one push of 0x0C3 gives data_out=0x0C3, count=1.
